// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and store lane steering.
// Latency: ex_bus_o is registered (1 cycle); flush, branch and memory-control outputs are combinational.
// Backpressure: none; a stalled or bubble ID/EX entry registers a NOP and suppresses all side effects.
//
// Ports:
//   clk, rst                      clock; synchronous active-low reset
//   bus_i                         ID/EX register contents
//   fw_cntrl_i                    per-operand forwarding select (0 reg, 1 mem, 2 wb, 3 wb_late)
//   mem_/wb_/wb_late_bypass_i     results from younger-to-older pipeline positions
//   ex_bus_o                      registered EX/MEM bus
//   flush_o, br_bus_o             redirect to IF and squash of IF/ID
//   ex2mem_o, ld_addr             data-memory control and effective address

package core;

  typedef enum logic [4:0] {
    ALU_NOP = 5'd0, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_AUIPC, ALU_JAL, ALU_JALR,
    ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
  } alu_op_t;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_op_t;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_LOAD
  } format_t;

  // An all-zero bus (alu_op == ALU_NOP) is a bubble.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] rd_res;
    alu_op_t     alu_op;
    mem_op_t     mem_op;
    format_t     format;
    logic        rf_wr_en;
    logic        pipeline_stall;
  } pipeline_bus_t;

  typedef struct packed {
    logic [1:0] rs1_sel;
    logic [1:0] rs2_sel;
  } fw_cntrl_bus_t;

  typedef struct packed {
    logic [31:0] data;
  } bypass_bus_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] branch_target;
  } br_cntrl_bus_t;

  typedef struct packed {
    mem_op_t     mem_op;
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [3:0]  be;
  } mem_cntrl_bus_t;

endpackage

module ex_stage (
  input  logic                 clk,
  input  logic                 rst,
  input  core::pipeline_bus_t  bus_i,
  input  core::fw_cntrl_bus_t  fw_cntrl_i,
  input  core::bypass_bus_t    mem_bypass_i,
  input  core::bypass_bus_t    wb_bypass_i,
  input  core::bypass_bus_t    wb_late_bypass_i,
  output core::pipeline_bus_t  ex_bus_o,
  output logic                 flush_o,
  output core::br_cntrl_bus_t  br_bus_o,
  output core::mem_cntrl_bus_t ex2mem_o,
  output logic [31:0]          ld_addr
);
  import core::*;

  logic          active;     // real instruction, not stalled, not in reset
  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic [31:0]   alu_b;
  logic [31:0]   eff_addr;
  logic [31:0]   alu_res;
  logic [31:0]   pc_plus4;
  logic [31:0]   pc_plus_imm;
  logic          is_jump;
  logic          is_branch;
  logic          br_cond;
  logic          taken;
  logic [3:0]    be;
  logic [31:0]   w_data;
  pipeline_bus_t ex_nxt;

  assign active = rst && !bus_i.pipeline_stall && (bus_i.alu_op != ALU_NOP);

  // Forwarding muxes. The select already encodes priority (mem is nearest),
  // so the mux just obeys it; x0 always reads as zero.
  always_comb begin
    op_a = bus_i.rs1_data;
    case (fw_cntrl_i.rs1_sel)
      2'd1:    op_a = mem_bypass_i.data;
      2'd2:    op_a = wb_bypass_i.data;
      2'd3:    op_a = wb_late_bypass_i.data;
      default: op_a = bus_i.rs1_data;
    endcase
    if (bus_i.rs1 == 5'd0) op_a = '0;
  end

  always_comb begin
    op_b = bus_i.rs2_data;
    case (fw_cntrl_i.rs2_sel)
      2'd1:    op_b = mem_bypass_i.data;
      2'd2:    op_b = wb_bypass_i.data;
      2'd3:    op_b = wb_late_bypass_i.data;
      default: op_b = bus_i.rs2_data;
    endcase
    if (bus_i.rs2 == 5'd0) op_b = '0;
  end

  assign alu_b       = (bus_i.format == FMT_R || bus_i.format == FMT_B) ? op_b : bus_i.imm;
  assign eff_addr    = op_a + bus_i.imm;
  assign pc_plus4    = bus_i.pc + 32'd4;
  assign pc_plus_imm = bus_i.pc + bus_i.imm;

  always_comb begin
    alu_res   = '0;
    is_jump   = 1'b0;
    is_branch = 1'b0;
    br_cond   = 1'b0;
    case (bus_i.alu_op)
      ALU_ADD:   alu_res = op_a + alu_b;
      ALU_SUB:   alu_res = op_a - alu_b;
      ALU_AND:   alu_res = op_a & alu_b;
      ALU_OR:    alu_res = op_a | alu_b;
      ALU_XOR:   alu_res = op_a ^ alu_b;
      ALU_SLT:   alu_res = {31'd0, $signed(op_a) < $signed(alu_b)};
      ALU_SLTU:  alu_res = {31'd0, op_a < alu_b};
      ALU_SLL:   alu_res = op_a << alu_b[4:0];
      ALU_SRL:   alu_res = op_a >> alu_b[4:0];
      ALU_SRA:   alu_res = $signed(op_a) >>> alu_b[4:0];
      ALU_LUI:   alu_res = bus_i.imm;
      ALU_AUIPC: alu_res = pc_plus_imm;
      ALU_JAL, ALU_JALR: begin
        alu_res = pc_plus4;
        is_jump = 1'b1;
      end
      ALU_BEQ:  begin is_branch = 1'b1; br_cond = (op_a == op_b); end
      ALU_BNE:  begin is_branch = 1'b1; br_cond = (op_a != op_b); end
      ALU_BLT:  begin is_branch = 1'b1; br_cond = ($signed(op_a) <  $signed(op_b)); end
      ALU_BGE:  begin is_branch = 1'b1; br_cond = ($signed(op_a) >= $signed(op_b)); end
      ALU_BLTU: begin is_branch = 1'b1; br_cond = (op_a <  op_b); end
      ALU_BGEU: begin is_branch = 1'b1; br_cond = (op_a >= op_b); end
      default:  alu_res = '0;
    endcase
  end

  assign taken   = active && (is_jump || (is_branch && br_cond));
  assign flush_o = taken;

  always_comb begin
    br_bus_o.taken         = taken;
    br_bus_o.branch_target = pc_plus_imm;
    if (bus_i.alu_op == ALU_JALR) br_bus_o.branch_target = {eff_addr[31:1], 1'b0};
  end

  // Store data is replicated so the memory only has to honour the lane enables.
  always_comb begin
    be     = 4'b0000;
    w_data = op_b;
    case (bus_i.mem_op)
      MEM_SB: begin
        w_data = {4{op_b[7:0]}};
        be     = 4'b0001 << eff_addr[1:0];
      end
      MEM_SH: begin
        w_data = {2{op_b[15:0]}};
        be     = eff_addr[1] ? 4'b1100 : 4'b0011;
      end
      MEM_SW: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (!active) be = 4'b0000;
  end

  assign ld_addr          = eff_addr;
  assign ex2mem_o.addr    = eff_addr;
  assign ex2mem_o.w_data  = w_data;
  assign ex2mem_o.be      = be;
  assign ex2mem_o.mem_op  = active ? bus_i.mem_op : MEM_NONE;

  always_comb begin
    ex_nxt          = bus_i;
    ex_nxt.rs1_data = op_a;
    ex_nxt.rs2_data = op_b;
    ex_nxt.rd_res   = alu_res;
    ex_nxt.rf_wr_en = bus_i.rf_wr_en && (bus_i.rd != 5'd0);
  end

  // Reset, stall and bubble all register the all-zero NOP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_bus_o <= '0;
    end else if (!active) begin
      ex_bus_o <= '0;
    end else begin
      ex_bus_o <= ex_nxt;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  import core::*;

  logic           clk;
  logic           rst;
  pipeline_bus_t  bus;
  fw_cntrl_bus_t  fw;
  bypass_bus_t    byp_mem, byp_wb, byp_late;
  pipeline_bus_t  ex_bus;
  logic           flush;
  br_cntrl_bus_t  br;
  mem_cntrl_bus_t m;
  logic [31:0]    ld_addr;

  int total = 0;
  int bad   = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .bus_i(bus), .fw_cntrl_i(fw),
    .mem_bypass_i(byp_mem), .wb_bypass_i(byp_wb), .wb_late_bypass_i(byp_late),
    .ex_bus_o(ex_bus), .flush_o(flush), .br_bus_o(br), .ex2mem_o(m), .ld_addr(ld_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    alu_op_t     op;
    format_t     fmt;
    mem_op_t     mop;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
    logic [1:0]  s1, s2;
    logic [31:0] bm, bw, bl;
    logic        wr, stall;
    logic        e_flush;
    logic [31:0] e_tgt;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_ld, e_res;
    logic [4:0]  e_rd;
    logic        e_wr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus                = '0;
    bus.alu_op         = v.op;
    bus.format         = v.fmt;
    bus.mem_op         = v.mop;
    bus.rs1            = v.rs1;
    bus.rs2            = v.rs2;
    bus.rd             = v.rd;
    bus.rs1_data       = v.d1;
    bus.rs2_data       = v.d2;
    bus.imm            = v.imm;
    bus.pc             = v.pc;
    bus.rf_wr_en       = v.wr;
    bus.pipeline_stall = v.stall;
    fw.rs1_sel         = v.s1;
    fw.rs2_sel         = v.s2;
    byp_mem.data       = v.bm;
    byp_wb.data        = v.bw;
    byp_late.data      = v.bl;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    chk({v.name, ".flush"}, 256'(flush), 256'(v.e_flush));
    chk({v.name, ".taken"}, 256'(br.taken), 256'(v.e_flush));
    if (v.e_flush) chk({v.name, ".target"}, 256'(br.branch_target), 256'(v.e_tgt));
    chk({v.name, ".be"}, 256'(m.be), 256'(v.e_be));
    if (v.e_be != 4'b0000) chk({v.name, ".w_data"}, 256'(m.w_data), 256'(v.e_wd));
    chk({v.name, ".ld_addr"}, 256'(ld_addr), 256'(v.e_ld));
    chk({v.name, ".addr"}, 256'(m.addr), 256'(v.e_ld));
    @(posedge clk);
    #1;
    chk({v.name, ".rd_res"}, 256'(ex_bus.rd_res), 256'(v.e_res));
    chk({v.name, ".rd"}, 256'(ex_bus.rd), 256'(v.e_rd));
    chk({v.name, ".rf_wr_en"}, 256'(ex_bus.rf_wr_en), 256'(v.e_wr));
  endtask

  initial begin
    vec_t v;
    //                name          op         fmt       mop       rs1 rs2 rd  d1            d2            imm           pc        s1 s2 bm         bw         bl            wr stall | flush tgt       be       wd            ld            res           rd wr
    vecs.push_back(vec_t'{"addi_x5",   ALU_ADD,  FMT_I,    MEM_NONE, 1, 0, 5, 32'h0,        32'h0,        32'd14,       32'h0,    0, 0, 32'h11,    32'h22,    32'h33,       1, 0, 0, 32'h0,   4'b0000, 32'h0,        32'hE,        32'd14,       5, 1});
    vecs.push_back(vec_t'{"fwd_mem",   ALU_ADD,  FMT_I,    MEM_NONE, 7, 0, 2, 32'h999,      32'h0,        32'd5,        32'h0,    1, 0, 32'h10,    32'h77,    32'h88,       1, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h15,       32'h15,       2, 1});
    vecs.push_back(vec_t'{"fwd_late",  ALU_ADD,  FMT_I,    MEM_NONE, 7, 0, 2, 32'h999,      32'h0,        32'd5,        32'h0,    3, 0, 32'h10,    32'h77,    32'hFFFFFFFF, 1, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h4,        32'h4,        2, 1});
    vecs.push_back(vec_t'{"fwd_wb",    ALU_ADD,  FMT_I,    MEM_NONE, 7, 0, 2, 32'h999,      32'h0,        32'd5,        32'h0,    2, 0, 32'h10,    32'h20,    32'h88,       1, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h25,       32'h25,       2, 1});
    vecs.push_back(vec_t'{"lw_addr",   ALU_ADD,  FMT_LOAD, MEM_LW,   7, 0, 3, 32'h100,      32'h0,        32'd12,       32'h0,    0, 0, 32'h11,    32'h22,    32'h33,       1, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h10C,      32'h10C,      3, 1});
    vecs.push_back(vec_t'{"beq_take",  ALU_BEQ,  FMT_B,    MEM_NONE, 1, 2, 0, 32'h5,        32'h5,        32'd8,        32'h20,   0, 0, 32'h11,    32'h22,    32'h33,       0, 0, 1, 32'h28,  4'b0000, 32'h0,        32'hD,        32'h0,        0, 0});
    vecs.push_back(vec_t'{"beq_not",   ALU_BEQ,  FMT_B,    MEM_NONE, 1, 2, 0, 32'h5,        32'h6,        32'd8,        32'h20,   0, 0, 32'h11,    32'h22,    32'h33,       0, 0, 0, 32'h0,   4'b0000, 32'h0,        32'hD,        32'h0,        0, 0});
    vecs.push_back(vec_t'{"sb_lane2",  ALU_ADD,  FMT_S,    MEM_SB,   1, 2, 0, 32'h1000,     32'hAB,       32'd2,        32'h0,    0, 0, 32'h11,    32'h22,    32'h33,       0, 0, 0, 32'h0,   4'b0100, 32'hABABABAB, 32'h1002,     32'h1002,     0, 0});
    vecs.push_back(vec_t'{"sub",       ALU_SUB,  FMT_R,    MEM_NONE, 1, 2, 3, 32'h5,        32'h7,        32'h0,        32'h0,    0, 0, 32'h11,    32'h22,    32'h33,       1, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h5,        32'hFFFFFFFE, 3, 1});
    vecs.push_back(vec_t'{"x0_force",  ALU_ADD,  FMT_I,    MEM_NONE, 0, 0, 6, 32'h99,       32'h0,        32'd3,        32'h0,    1, 0, 32'h55,    32'h22,    32'h33,       1, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h3,        32'h3,        6, 1});
    vecs.push_back(vec_t'{"rd_x0",     ALU_ADD,  FMT_I,    MEM_NONE, 1, 0, 0, 32'h9,        32'h0,        32'd1,        32'h0,    0, 0, 32'h11,    32'h22,    32'h33,       1, 0, 0, 32'h0,   4'b0000, 32'h0,        32'hA,        32'hA,        0, 0});
    vecs.push_back(vec_t'{"jal_stall", ALU_JAL,  FMT_J,    MEM_NONE, 0, 0, 1, 32'h0,        32'h0,        32'h100,      32'h40,   0, 0, 32'h11,    32'h22,    32'h33,       1, 1, 0, 32'h0,   4'b0000, 32'h0,        32'h100,      32'h0,        0, 0});
    vecs.push_back(vec_t'{"sw_stall",  ALU_ADD,  FMT_S,    MEM_SW,   1, 2, 0, 32'h200,      32'hDEAD,     32'h0,        32'h0,    0, 0, 32'h11,    32'h22,    32'h33,       0, 1, 0, 32'h0,   4'b0000, 32'h0,        32'h200,      32'h0,        0, 0});
    vecs.push_back(vec_t'{"jal",       ALU_JAL,  FMT_J,    MEM_NONE, 0, 0, 1, 32'h0,        32'h0,        32'h100,      32'h40,   0, 0, 32'h11,    32'h22,    32'h33,       1, 0, 1, 32'h140, 4'b0000, 32'h0,        32'h100,      32'h44,       1, 1});
    vecs.push_back(vec_t'{"jalr",      ALU_JALR, FMT_I,    MEM_NONE, 1, 0, 1, 32'h203,      32'h0,        32'd4,        32'h80,   0, 0, 32'h11,    32'h22,    32'h33,       1, 0, 1, 32'h206, 4'b0000, 32'h0,        32'h207,      32'h84,       1, 1});
    vecs.push_back(vec_t'{"sra",       ALU_SRA,  FMT_R,    MEM_NONE, 1, 2, 3, 32'h80000000, 32'h24,       32'h0,        32'h0,    0, 0, 32'h11,    32'h22,    32'h33,       1, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h80000000, 32'hF8000000, 3, 1});
    vecs.push_back(vec_t'{"sll",       ALU_SLL,  FMT_R,    MEM_NONE, 1, 2, 3, 32'h1,        32'h21,       32'h0,        32'h0,    0, 0, 32'h11,    32'h22,    32'h33,       1, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h1,        32'h2,        3, 1});
    vecs.push_back(vec_t'{"slt",       ALU_SLT,  FMT_R,    MEM_NONE, 1, 2, 3, 32'h1,        32'hFFFFFFFF, 32'h0,        32'h0,    0, 0, 32'h11,    32'h22,    32'h33,       1, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h1,        32'h0,        3, 1});
    vecs.push_back(vec_t'{"sltu",      ALU_SLTU, FMT_R,    MEM_NONE, 1, 2, 3, 32'h1,        32'hFFFFFFFF, 32'h0,        32'h0,    0, 0, 32'h11,    32'h22,    32'h33,       1, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h1,        32'h1,        3, 1});
    vecs.push_back(vec_t'{"bltu_back", ALU_BLTU, FMT_B,    MEM_NONE, 1, 2, 0, 32'h1,        32'hFFFFFFFF, 32'hFFFFFFFC, 32'h10,   0, 0, 32'h11,    32'h22,    32'h33,       0, 0, 1, 32'hC,   4'b0000, 32'h0,        32'hFFFFFFFD, 32'h0,        0, 0});
    vecs.push_back(vec_t'{"bge_sgn",   ALU_BGE,  FMT_B,    MEM_NONE, 1, 2, 0, 32'hFFFFFFFF, 32'h1,        32'd8,        32'h0,    0, 0, 32'h11,    32'h22,    32'h33,       0, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h7,        32'h0,        0, 0});
    vecs.push_back(vec_t'{"sh_hi",     ALU_ADD,  FMT_S,    MEM_SH,   1, 2, 0, 32'h302,      32'h1234,     32'h0,        32'h0,    0, 0, 32'h11,    32'h22,    32'h33,       0, 0, 0, 32'h0,   4'b1100, 32'h12341234, 32'h302,      32'h302,      0, 0});
    vecs.push_back(vec_t'{"lui",       ALU_LUI,  FMT_U,    MEM_NONE, 0, 0, 4, 32'h0,        32'h0,        32'hABCDE000, 32'h0,    0, 0, 32'h11,    32'h22,    32'h33,       1, 0, 0, 32'h0,   4'b0000, 32'h0,        32'hABCDE000, 32'hABCDE000, 4, 1});
    vecs.push_back(vec_t'{"auipc",     ALU_AUIPC,FMT_U,    MEM_NONE, 0, 0, 4, 32'h0,        32'h0,        32'h1000,     32'h40,   0, 0, 32'h11,    32'h22,    32'h33,       1, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h1000,     32'h1040,     4, 1});
    vecs.push_back(vec_t'{"xor",       ALU_XOR,  FMT_R,    MEM_NONE, 1, 2, 3, 32'hF0F0,     32'h0FF0,     32'h0,        32'h0,    0, 0, 32'h11,    32'h22,    32'h33,       1, 0, 0, 32'h0,   4'b0000, 32'h0,        32'hF0F0,     32'hFF00,     3, 1});
    vecs.push_back(vec_t'{"rs2_fwd",   ALU_ADD,  FMT_R,    MEM_NONE, 1, 2, 3, 32'h1,        32'h5,        32'h0,        32'h0,    0, 2, 32'h11,    32'h30,    32'h33,       1, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h1,        32'h31,       3, 1});
    vecs.push_back(vec_t'{"bubble",    ALU_NOP,  FMT_NONE, MEM_NONE, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,    0, 0, 32'h0,     32'h0,     32'h0,        0, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        32'h0,        0, 0});

    // Reset held from time 0: a taken jump and a store must stay silent.
    rst = 1'b0;
    drive(vecs[13]);
    #1;
    chk("rst.flush", 256'(flush), 256'(0));
    chk("rst.taken", 256'(br.taken), 256'(0));
    @(negedge clk);
    drive(vecs[21]);
    #1;
    chk("rst.be", 256'(m.be), 256'(0));
    @(posedge clk);
    #1;
    chk("rst.ex_bus", 256'(ex_bus), 256'(0));
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset mid-sequence: an in-flight store is discarded, then operation resumes.
    run_vec(vecs[0]);
    @(negedge clk);
    drive(vecs[7]);
    #1;
    chk("mid.be_before", 256'(m.be), 256'(4'b0100));
    rst = 1'b0;
    #1;
    chk("mid.be_in_rst", 256'(m.be), 256'(0));
    @(posedge clk);
    #1;
    chk("mid.ex_bus", 256'(ex_bus), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    v = vecs[1];
    v.name = "resume";
    run_vec(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
